// File: rtl/morph_pkg.sv
// Shared definitions for the morphological window generator and kernel:
// default pixel width and operator size, tap count, FSM states, tap indexing.
package morph_pkg;

  localparam int MORPH_VIDEO_DATA_WIDTH = 8;
  localparam int MORPH_OPERATOR_SIZE    = 3;
  localparam int MORPH_OP_SIZE          = MORPH_OPERATOR_SIZE * MORPH_OPERATOR_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } win_state_e;

  // Row-major tap index: r=0 is the oldest row, c=0 the oldest column.
  function automatic int tap_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

// File: rtl/morph_line_buf.sv
// One line of pixel storage: single port, asynchronous read, synchronous write,
// so a read-modify-write shift happens within one accepted pixel.
module morph_line_buf #(
  parameter int VIDEO_DATA_WIDTH = 8,
  parameter int IMG_WIDTH        = 640,
  parameter int ADDR_W           = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [VIDEO_DATA_WIDTH-1:0] wdata,
  output logic [VIDEO_DATA_WIDTH-1:0] rdata
);

  logic [VIDEO_DATA_WIDTH-1:0] mem_q [IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/morph_window_gen.sv
// Raster stream to OPERATOR_SIZE x OPERATOR_SIZE window generator feeding the
// erode/dilate kernel. Define MORPH_WIN_SOF_EN to add the out_sof port.
module morph_window_gen
  import morph_pkg::*;
#(
  parameter int VIDEO_DATA_WIDTH = MORPH_VIDEO_DATA_WIDTH,
  parameter int OPERATOR_SIZE    = MORPH_OPERATOR_SIZE,
  parameter int IMG_WIDTH        = 640,
  localparam int OP_SIZE         = OPERATOR_SIZE * OPERATOR_SIZE
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [VIDEO_DATA_WIDTH-1:0]         in_data,
  input  logic                                in_valid,
  input  logic                                in_sof,
  input  logic                                in_eol,
  output logic [OP_SIZE*VIDEO_DATA_WIDTH-1:0] out_data,
  output logic                                out_valid,
  output logic                                err_len
`ifdef MORPH_WIN_SOF_EN
  ,
  output logic                                out_sof
`endif
);

  localparam int N      = OPERATOR_SIZE;
  localparam int W      = VIDEO_DATA_WIDTH;
  localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W  = $clog2(N);

  localparam logic [ADDR_W-1:0] COL_LAST      = ADDR_W'(IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] COL_FIRST_WIN = ADDR_W'(N - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(N - 1);
  localparam logic [ROW_W-1:0]  ROW_FILL_END  = ROW_W'(N - 2);

  win_state_e        state_q, state_d, state_eff;
  logic [ADDR_W-1:0] col_q, col_d, col_eff;
  logic [ROW_W-1:0]  row_q, row_d, row_eff;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic              accept, at_last, wrap;

  logic [W-1:0] win_q   [N][N];
  logic [W-1:0] win_d   [N][N];
  logic [W-1:0] col_new [N];
  logic [W-1:0] lb_rd   [N-1];
  logic [W-1:0] lb_wd   [N-1];

  // Line buffer j holds the line j+1 rows above the current one; writes cascade down.
  for (genvar j = 0; j < N - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_wd[j] = in_data;
    end else begin : g_chain
      assign lb_wd[j] = lb_rd[j-1];
    end
    morph_line_buf #(
      .VIDEO_DATA_WIDTH(W),
      .IMG_WIDTH       (IMG_WIDTH),
      .ADDR_W          (ADDR_W)
    ) u_line_buf (
      .clk  (clk),
      .we   (accept),
      .addr (col_eff),
      .wdata(lb_wd[j]),
      .rdata(lb_rd[j])
    );
  end

  always_comb begin
    accept    = in_valid && ((state_q != ST_IDLE) || in_sof);
    // A start of frame restarts the position and clears the error for this very pixel.
    col_eff   = in_sof ? '0 : col_q;
    row_eff   = in_sof ? '0 : row_q;
    state_eff = in_sof ? ST_FILL : state_q;
    at_last   = (col_eff == COL_LAST);
    wrap      = in_eol || at_last;

    col_new[N-1] = in_data;
    for (int j = 0; j < N - 1; j++) col_new[N-2-j] = lb_rd[j];

    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    win_d       = win_q;

    if (accept) begin
      state_d = state_eff;
      if (state_eff == ST_FILL && wrap && row_eff == ROW_FILL_END) state_d = ST_RUN;
      col_d = wrap ? '0 : col_eff + 1'b1;
      row_d = (wrap && row_eff != ROW_LAST) ? row_eff + 1'b1 : row_eff;
      err_d = (in_sof ? 1'b0 : err_q) | (at_last & ~in_eol);
      // Left-edge gate keeps windows from straddling two lines.
      out_valid_d = (state_eff == ST_RUN) && (col_eff >= COL_FIRST_WIN);
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][N-1] = col_new[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) win_q[r][c] <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      win_q       <= win_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        out_data[tap_idx(r, c, N)*W +: W] = win_q[r][c];
  end

  assign out_valid = out_valid_q;
  assign err_len   = err_q;

`ifdef MORPH_WIN_SOF_EN
  logic sof_pend_q, sof_pend_d;
  logic out_sof_q, out_sof_d;

  // Pending flag marks that no window has been emitted yet since the last start of frame.
  always_comb begin
    sof_pend_d = sof_pend_q;
    out_sof_d  = 1'b0;
    if (accept) begin
      out_sof_d  = out_valid_d & (in_sof | sof_pend_q);
      sof_pend_d = (in_sof | sof_pend_q) & ~out_valid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_pend_q <= 1'b0;
      out_sof_q  <= 1'b0;
    end else begin
      sof_pend_q <= sof_pend_d;
      out_sof_q  <= out_sof_d;
    end
  end

  assign out_sof = out_sof_q;
`endif

endmodule

// File: tb/tb_morph_window_gen.sv
// Bench for morph_window_gen (IMG_WIDTH=8, 3x3): directed frames plus random
// frames checked against an image-array reference model.
module tb_morph_window_gen;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int IW = 8;
  localparam int OW = N * N * W;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid, in_sof, in_eol;
  logic [OW-1:0] out_data;
  logic          out_valid, err_len;
`ifdef MORPH_WIN_SOF_EN
  logic          out_sof;
`endif

  morph_window_gen #(
    .VIDEO_DATA_WIDTH(W),
    .OPERATOR_SIZE   (N),
    .IMG_WIDTH       (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_eol   (in_eol),
    .out_data (out_data),
    .out_valid(out_valid),
    .err_len  (err_len)
`ifdef MORPH_WIN_SOF_EN
    ,
    .out_sof  (out_sof)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  bit            exp_sof_q[$];
  bit            got_sof_q[$];

  int            hold_err       = 0;
  int            idle_valid_err = 0;
  int            sof_stray      = 0;
  logic          prev_in_valid  = 1'b0;
  logic [OW-1:0] prev_out_data  = '0;

  // Reference model: the frame as a plain image array, windows cut from it.
  int m_img [16][IW];
  bit m_active   = 0;
  int m_row      = 0;
  int m_col      = 0;
  bit m_sof_pend = 0;

  function automatic void model_pixel(input int d, input bit s, input bit e);
    logic [OW-1:0] w;
    if (s) begin
      m_active = 1; m_row = 0; m_col = 0; m_sof_pend = 1;
    end
    if (!m_active) return;
    if (m_row < 16) m_img[m_row][m_col] = d;
    if (m_row >= N - 1 && m_row < 16 && m_col >= N - 1) begin
      w = '0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w[(i*N+j)*W +: W] = W'(m_img[m_row-(N-1)+i][m_col-(N-1)+j]);
      exp_q.push_back(w);
      exp_sof_q.push_back(m_sof_pend);
      m_sof_pend = 0;
    end
    if (e || m_col == IW - 1) begin
      m_col = 0; m_row++;
    end else begin
      m_col++;
    end
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_valid === 1'b1) begin
        got_q.push_back(out_data);
`ifdef MORPH_WIN_SOF_EN
        got_sof_q.push_back(out_sof);
`endif
      end
      if (prev_in_valid === 1'b0 && out_valid !== 1'b0) idle_valid_err <= idle_valid_err + 1;
      if (prev_in_valid === 1'b0 && out_data !== prev_out_data) hold_err <= hold_err + 1;
`ifdef MORPH_WIN_SOF_EN
      if (out_sof === 1'b1 && out_valid !== 1'b1) sof_stray <= sof_stray + 1;
`endif
    end
    prev_in_valid <= in_valid;
    prev_out_data <= out_data;
  end

  task automatic step(input logic v, input int d, input logic s, input logic e);
    in_valid = v;
    in_data  = W'(d);
    in_sof   = s;
    in_eol   = e;
    if (v) model_pixel(d, s, e);
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous, 1: valid toggles every cycle, 2: random idle gaps
  task automatic drive_frame(input int h, input int wd, input int base, input bit rnd, input int mode);
    int d;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < wd; c++) begin
        d = rnd ? int'($urandom_range(0, 255)) : base + r * 8 + c;
        step(1'b1, d, (r == 0 && c == 0), (c == wd - 1));
        if (mode == 1) step(1'b0, 0, 1'b0, 1'b0);
        if (mode == 2 && $urandom_range(0, 99) < 30) step(1'b0, 0, 1'b0, 1'b0);
      end
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_len); end
`ifdef MORPH_WIN_SOF_EN
    checks++; if (out_sof !== 1'b0) begin failures++; $display("FAIL reset_sof got=%b exp=0", out_sof); end
`endif
    rst = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_frame;
    int gb = got_q.size();
    int eb = exp_q.size();
    int n;
    logic [OW-1:0] first_w = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    logic [OW-1:0] last_w;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        step(1'b1, r * 8 + c, (r == 0 && c == 0), (c == 7));
        if (r == 2 && c == 1) begin
          checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL early_valid got=%b exp=0", out_valid); end
        end
        if (r == 2 && c == 2) begin
          checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", out_valid); end
          checks++; if (out_data !== first_w) begin failures++; $display("FAIL first_window got=%h exp=%h", out_data, first_w); end
        end
      end
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    n = got_q.size() - gb;
    checks++; if (n != 12) begin failures++; $display("FAIL frame_count got=%0d exp=12", n); end
    last_w = (n > 0) ? got_q[got_q.size()-1] : 'x;
    checks++; if (last_w[8*W +: W] !== 8'd31) begin failures++; $display("FAIL last_tap8 got=%0d exp=31", last_w[8*W +: W]); end
    checks++; if (last_w[0 +: W] !== 8'd13) begin failures++; $display("FAIL last_tap0 got=%0d exp=13", last_w[0 +: W]); end
    for (int i = 0; i < n && i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL frame_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL frame_err got=%b exp=0", err_len); end
  endtask

  task automatic test_toggle;
    int gb = got_q.size();
    int eb = exp_q.size();
    int hb = hold_err;
    int vb = idle_valid_err;
    int n;
    drive_frame(4, 8, 0, 1'b0, 1);
    n = got_q.size() - gb;
    checks++; if (n != 12) begin failures++; $display("FAIL toggle_count got=%0d exp=12", n); end
    for (int i = 0; i < n && i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL toggle_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++; if (idle_valid_err != vb) begin failures++; $display("FAIL toggle_idle_valid got=%0d exp=%0d", idle_valid_err, vb); end
    checks++; if (hold_err != hb) begin failures++; $display("FAIL toggle_hold got=%0d exp=%0d", hold_err, hb); end
  endtask

  task automatic test_restart;
    int gb = got_q.size();
    int eb = exp_q.size();
    int n;
    int mixed = 0;
    int lo, hi;
    logic [OW-1:0] w;
    for (int p = 0; p < 2 * 8 + 4; p++)
      step(1'b1, p, (p == 0), (p % 8 == 7));
    drive_frame(4, 8, 100, 1'b0, 0);
    n = got_q.size() - gb;
    checks++; if (n != 14) begin failures++; $display("FAIL restart_count got=%0d exp=14", n); end
    w = (n > 2) ? got_q[gb+2] : 'x;
    checks++; if (w[8*W +: W] !== 8'd118) begin failures++; $display("FAIL restart_tap8 got=%0d exp=118", w[8*W +: W]); end
    for (int i = 0; i < n; i++) begin
      lo = 0; hi = 0;
      for (int k = 0; k < N * N; k++)
        if (got_q[gb+i][k*W +: W] >= 100) hi++; else lo++;
      if (lo != 0 && hi != 0) mixed++;
    end
    checks++; if (mixed != 0) begin failures++; $display("FAIL restart_mixed got=%0d exp=0", mixed); end
    for (int i = 0; i < n && i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL restart_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL restart_err got=%b exp=0", err_len); end
  endtask

  task automatic test_len_err;
    int gb = got_q.size();
    int eb = exp_q.size();
    int n;
    for (int p = 0; p < 3 * 8; p++) begin
      step(1'b1, int'($urandom_range(0, 255)), (p == 0), 1'b0);
      if (p == 6) begin
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", err_len); end
      end
      if (p == 7) begin
        checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_len); end
      end
    end
    step(1'b0, 0, 1'b0, 1'b0);
    checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_len); end
    n = got_q.size() - gb;
    checks++; if (n != 6) begin failures++; $display("FAIL err_count got=%0d exp=6", n); end
    for (int i = 0; i < n && i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL err_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
    step(1'b1, 5, 1'b1, 1'b0);
    checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_len); end
    step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_rst_mid;
    int gb, eb, n;
    logic [OW-1:0] first_w = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
    for (int p = 0; p < 2 * 8 + 5; p++)
      step(1'b1, p + 40, (p == 0), (p >= 8 && p % 8 == 7));
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL prerst_valid got=%b exp=1", out_valid); end
    checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL prerst_err got=%b exp=1", err_len); end
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_data got=%h exp=0", out_data); end
    checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_len); end
    m_active = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    gb = got_q.size();
    for (int p = 0; p < 10; p++) step(1'b1, int'($urandom_range(0, 255)), 1'b0, (p % 8 == 7));
    step(1'b0, 0, 1'b0, 1'b0);
    checks++; if (got_q.size() != gb) begin failures++; $display("FAIL idle_ignored got=%0d exp=%0d", got_q.size(), gb); end
    gb = got_q.size();
    eb = exp_q.size();
    drive_frame(4, 8, 0, 1'b0, 0);
    n = got_q.size() - gb;
    checks++; if (n != 12) begin failures++; $display("FAIL rerun_count got=%0d exp=12", n); end
    checks++; if (n == 0 || got_q[gb] !== first_w) begin failures++; $display("FAIL rerun_first got=%h exp=%h", (n > 0) ? got_q[gb] : 'x, first_w); end
    for (int i = 0; i < n && i < exp_q.size() - eb; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL rerun_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_random;
    int gb = got_q.size();
    int eb = exp_q.size();
    int n, ne;
    for (int f = 0; f < 5; f++)
      drive_frame(int'($urandom_range(3, 5)), int'($urandom_range(3, 8)), 0, 1'b1, 2);
    n  = got_q.size() - gb;
    ne = exp_q.size() - eb;
    checks++; if (n != ne) begin failures++; $display("FAIL random_count got=%0d exp=%0d", n, ne); end
    for (int i = 0; i < n && i < ne; i++) begin
      checks++;
      if (got_q[gb+i] !== exp_q[eb+i]) begin failures++; $display("FAIL random_win%0d got=%h exp=%h", i, got_q[gb+i], exp_q[eb+i]); end
    end
  endtask

`ifdef MORPH_WIN_SOF_EN
  task automatic test_sof;
    int gb = got_q.size();
    int eb = exp_q.size();
    int sb = sof_stray;
    int n;
    logic [W-1:0] t8;
    drive_frame(4, 8, 0, 1'b0, 0);
    drive_frame(4, 8, 0, 1'b0, 1);
    n = got_q.size() - gb;
    checks++; if (n != 24) begin failures++; $display("FAIL sof_count got=%0d exp=24", n); end
    for (int i = 0; i < n; i++) begin
      t8 = got_q[gb+i][8*W +: W];
      checks++;
      if (got_sof_q[gb+i] !== (t8 == 8'd18)) begin failures++; $display("FAIL sof_flag%0d got=%b exp=%b", i, got_sof_q[gb+i], (t8 == 8'd18)); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_sof_q[i] !== exp_sof_q[i]) begin failures++; $display("FAIL sof_model%0d got=%b exp=%b", i, got_sof_q[i], exp_sof_q[i]); end
    end
    checks++; if (sof_stray != sb) begin failures++; $display("FAIL sof_stray got=%0d exp=%0d", sof_stray, sb); end
    if (eb < 0) $display("unreachable");
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_toggle();
    test_restart();
    test_len_err();
    test_rst_mid();
    test_random();
`ifdef MORPH_WIN_SOF_EN
    test_sof();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morph_window_gen.md
Name: morph_window_gen

Overview:
- Upstream neighbour of the morphological erode/dilate kernel.
- Converts a raster pixel stream into an OPERATOR_SIZE x OPERATOR_SIZE window, packed as one wide word, with a one-cycle valid strobe.
- Holds OPERATOR_SIZE-1 line buffers and an N x N window register. Emits only full in-frame windows.
- No backpressure: the downstream kernel always accepts.

Parameters:
- VIDEO_DATA_WIDTH, 8, bits per pixel
- OPERATOR_SIZE, 3, window edge N; legal range 2..7
- IMG_WIDTH, 640, maximum line length, which is the line-buffer depth; power of two not required
- OP_SIZE (localparam), OPERATOR_SIZE*OPERATOR_SIZE, taps per window

Ports:
- clk  input  1  pixel clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  VIDEO_DATA_WIDTH  incoming pixel
- in_valid  input  1  in_data qualifier
- in_sof  input  1  first pixel of frame; meaningful only with in_valid
- in_eol  input  1  last pixel of line; meaningful only with in_valid
- out_data  output  OP_SIZE*VIDEO_DATA_WIDTH  window; tap k at bits [(k+1)*VIDEO_DATA_WIDTH-1 : k*VIDEO_DATA_WIDTH]
- out_valid  output  1  out_data holds a complete window
- err_len  output  1  sticky line-length error

Behaviour:
- Reset: asynchronous on rst=1, takes effect immediately.
  - state=IDLE, col=0, row=0, window register=0.
  - out_data=0, out_valid=0, err_len=0.
  - Line-buffer RAM contents are not cleared.
- Tap order: k = r*N + c.
  - r=0 is the oldest row (top); c=0 is the oldest column (left).
  - Tap OP_SIZE-1 is the current input pixel (bottom-right).
- Counters:
  - col counts 0..IMG_WIDTH-1 and advances on every accepted pixel.
  - in_eol, or col==IMG_WIDTH-1, wraps col to 0 and increments row. row saturates at N-1.
- States:
  - IDLE: in_valid pixels without in_sof are ignored. in_valid&in_sof → FILL, and that pixel is processed as (row 0, col 0).
  - FILL: rows 0..N-2 load the line buffers. The eol that ends row N-2 → RUN.
  - RUN: remains in RUN until the next in_sof.
  - in_sof in any state, including mid-line or mid-frame: frame aborted, counters forced to (0,0) for that pixel, state → FILL, err_len cleared.
- Per accepted pixel, i.e. in_valid=1, all in the same cycle:
  - Read line buffer j at address col (j=0 is the newest stored line).
  - Shift every window row left one column. The new right column is {linebuf[N-2], ..., linebuf[0], in_data} from top to bottom.
  - Write-shift: linebuf[0][col] ← in_data and linebuf[j][col] ← old linebuf[j-1][col]. This is read-before-write.
- Output:
  - out_valid is registered and asserted the cycle after an accepted pixel with state==RUN and col≥N-1 (col before wrap).
  - Latency is 1 clk.
  - out_data updates only on accepted pixels and holds otherwise.
  - out_valid=0 in every cycle following in_valid=0.
- Windows never straddle lines: the col≥N-1 gate discards left-edge mixtures. Windows per frame = (W-N+1)*(H-N+1).
- Length error: col reaching IMG_WIDTH-1 without in_eol sets err_len and forces the wrap. err_len stays set until in_sof or rst.
- in_sof and in_eol on the same pixel: the sof restart is applied first, then the eol wraps the line (a one-pixel line). Legal.
- A line shorter than N pixels yields no windows for that line. Line-buffer columns beyond the short line are left stale and are not an error.

Optional Feature:
- MORPH_WIN_SOF_EN defined: adds port out_sof (output, 1 bit), registered like out_valid.
  - Asserted with the first out_valid after each in_sof; 0 at all other times and after reset.
- Undefined: port absent; no logic generated.

Decomposition:
- Shared package morph_pkg: VIDEO_DATA_WIDTH and OPERATOR_SIZE defaults, OP_SIZE, and the tap-index function k=r*N+c. The morph kernel uses the same package.
- One sub-module: morph_line_buf.
  - Single-port, depth IMG_WIDTH, width VIDEO_DATA_WIDTH, asynchronous read and synchronous write.
  - Instantiated N-1 times in a generate loop.
- Counters, FSM and window register remain in the top.

Test Plan:
- Bench settings for all cases: IMG_WIDTH=8, N=3; 8x4 frame with pixel value = row*8+col, continuous in_valid, sof on (0,0), eol on col 7.
  - First out_valid one clk after pixel 18; taps 0..8 = 0,1,2,8,9,10,16,17,18.
  - Exactly 12 windows per frame; the last window has tap8=31 and tap0=13.
- Same frame with in_valid toggled 1/0 every cycle → identical 12 windows in order. out_valid is never asserted on consecutive cycles, and out_data holds between them.
- in_sof issued at pixel (2,4) of frame 1, then a full frame 2 (value+100) → no window mixes frame-1 rows. First window after the restart has tap8=118, and err_len=0.
- Line with no eol over 8 pixels → err_len=1 after pixel col 7 and remains high. The next in_sof clears it within 1 clk.
- rst pulse mid-RUN → out_valid, out_data and err_len are 0 immediately. Pixels without sof are ignored, and the next full frame reproduces scenario 1 exactly.
- MORPH_WIN_SOF_EN defined → out_sof high only alongside the window with tap8=18 in each frame.
